// File: rtl/ex_muldiv_unit.sv
// Purpose: iterative 16-bit multiply / restoring divide for the EX stage, signed or unsigned.
// Latency: start sampled in IDLE, done WIDTH+1 edges later; divide by zero finishes after one edge.
// Backpressure: stall holds IF/ID and ID/EX from the start cycle through BUSY; no queueing of starts.
// Ports: clk, reset (async active-low), flush (sync abort), start/is_div/is_signed/op1/op2 (request),
//        stall/busy (pipeline hold / not idle), done (1-cycle result strobe),
//        result_hi/result_lo (product halves or remainder/quotient), div_by_zero.
module ex_muldiv_unit #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             start,
    input  logic             is_div,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result_hi,
    output logic [WIDTH-1:0] result_lo,
    output logic             div_by_zero
);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    // Multiply: {partial product hi, multiplier shifting out}. Divide: {remainder, quotient shifting in}.
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opb_q, opb_d;
    logic               is_div_q, is_div_d;
    logic               neg_q, neg_d;
    logic               rem_neg_q, rem_neg_d;
    logic               dbz_q, dbz_d;
    logic [WIDTH-1:0]   res_hi_q, res_hi_d;
    logic [WIDTH-1:0]   res_lo_q, res_lo_d;
    logic               res_dbz_q, res_dbz_d;

    // Operand magnitudes; -2^(W-1) negates to itself, which is the correct unsigned magnitude.
    logic               sign1, sign2;
    logic [WIDTH-1:0]   mag1, mag2;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next, div_next, prod_fin;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH+1:0]   diff;
    logic [WIDTH-1:0]   quo, rem, fin_hi, fin_lo;

    always_comb begin
        sign1 = is_signed & op1[WIDTH-1];
        sign2 = is_signed & op2[WIDTH-1];
        mag1  = sign1 ? -op1 : op1;
        mag2  = sign2 ? -op2 : op2;

        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
        mul_next = {mul_sum, acc_q[WIDTH-1:1]};

        // Shifted remainder can reach WIDTH+1 bits; if its top bit is set the subtract always succeeds.
        rem_sh = acc_q[2*WIDTH-1:WIDTH-1];
        diff   = {1'b0, rem_sh} - {2'b00, opb_q};
        if (diff[WIDTH+1])
            div_next = {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        else
            div_next = {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

        // Sign fix-up; divide-by-zero captured with both sign flags clear so raw values pass through.
        prod_fin = neg_q ? -acc_q : acc_q;
        quo      = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem      = rem_neg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
        fin_hi   = is_div_q ? rem : prod_fin[2*WIDTH-1:WIDTH];
        fin_lo   = is_div_q ? quo : prod_fin[WIDTH-1:0];
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        opb_d     = opb_q;
        is_div_d  = is_div_q;
        neg_d     = neg_q;
        rem_neg_d = rem_neg_q;
        dbz_d     = dbz_q;
        res_hi_d  = res_hi_q;
        res_lo_d  = res_lo_q;
        res_dbz_d = res_dbz_q;

        if (flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        is_div_d = is_div;
                        if (is_div && op2 == '0) begin
                            acc_d     = {op1, {WIDTH{1'b1}}};
                            neg_d     = 1'b0;
                            rem_neg_d = 1'b0;
                            dbz_d     = 1'b1;
                            state_d   = S_DONE;
                        end else begin
                            acc_d     = {{WIDTH{1'b0}}, (is_div ? mag1 : mag2)};
                            opb_d     = is_div ? mag2 : mag1;
                            neg_d     = sign1 ^ sign2;
                            rem_neg_d = sign1;
                            dbz_d     = 1'b0;
                            cnt_d     = CNT_W'(WIDTH);
                            state_d   = S_BUSY;
                        end
                    end
                end
                S_BUSY: begin
                    acc_d = is_div_q ? div_next : mul_next;
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1))
                        state_d = S_DONE;
                end
                S_DONE: begin
                    // Latch at the end of the DONE cycle so a flush here leaves the held results untouched.
                    res_hi_d  = fin_hi;
                    res_lo_d  = fin_lo;
                    res_dbz_d = dbz_q;
                    state_d   = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            opb_q     <= '0;
            is_div_q  <= 1'b0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            dbz_q     <= 1'b0;
            res_hi_q  <= '0;
            res_lo_q  <= '0;
            res_dbz_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            opb_q     <= opb_d;
            is_div_q  <= is_div_d;
            neg_q     <= neg_d;
            rem_neg_q <= rem_neg_d;
            dbz_q     <= dbz_d;
            res_hi_q  <= res_hi_d;
            res_lo_q  <= res_lo_d;
            res_dbz_q <= res_dbz_d;
        end
    end

    // Start stalls combinationally so ID/EX holds on the very cycle the request appears.
    assign stall       = ((state_q == S_IDLE) & start) | (state_q == S_BUSY);
    assign busy        = (state_q != S_IDLE);
    assign done        = (state_q == S_DONE) & ~flush;
    assign result_hi   = done ? fin_hi : res_hi_q;
    assign result_lo   = done ? fin_lo : res_lo_q;
    assign div_by_zero = done ? dbz_q  : res_dbz_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
module tb_ex_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset, flush, start, is_div, is_signed;
    logic [15:0] op1, op2;
    logic        stall, busy, done, div_by_zero;
    logic [15:0] result_hi, result_lo;

    ex_muldiv_unit #(.WIDTH(16), .CNT_W(5)) dut (
        .clk(clk), .reset(reset), .flush(flush), .start(start),
        .is_div(is_div), .is_signed(is_signed), .op1(op1), .op2(op2),
        .stall(stall), .busy(busy), .done(done),
        .result_hi(result_hi), .result_lo(result_lo), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] hi;
        logic [15:0] lo;
        logic        dbz;
    } exp_t;

    exp_t        sb_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [15:0] last_hi = 16'h0, last_lo = 16'h0;
    logic        last_dbz = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (reset === 1'b1 && done === 1'b1) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: done=1 with no outstanding operation (hi=0x%0h lo=0x%0h)",
                         result_hi, result_lo);
            end else begin
                e = sb_q.pop_front();
                check("result_hi", {16'h0, result_hi}, {16'h0, e.hi});
                check("result_lo", {16'h0, result_lo}, {16'h0, e.lo});
                check("div_by_zero", {31'h0, div_by_zero}, {31'h0, e.dbz});
            end
        end
    end

    // Issue one operation, push its expectation, and check stall/latency profile.
    // poke=1 re-asserts start with other operands during BUSY; it must be ignored.
    task automatic run_op(input string name, input logic d, input logic s,
                          input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] e_hi, input logic [15:0] e_lo, input logic e_dbz,
                          input int e_stall, input int e_lat, input bit poke);
        int  stall_cnt;
        int  lat;
        bit  seen;
        exp_t e;
        e.hi = e_hi; e.lo = e_lo; e.dbz = e_dbz;
        @(posedge clk); #1;
        is_div = d; is_signed = s; op1 = a; op2 = b; start = 1'b1;
        sb_q.push_back(e);
        stall_cnt = 0; lat = 0; seen = 0;
        @(negedge clk);
        lat = 1;
        if (stall) stall_cnt++;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            lat++;
            if (done) begin
                seen = 1;
                check({name, "_stall_in_done"}, {31'h0, stall}, 32'h0);
            end else if (stall) begin
                stall_cnt++;
            end
            if (poke && i == 2) begin
                start = 1'b1; op1 = 16'h1234; op2 = 16'h0003; is_div = ~d;
            end else if (poke && i == 3) begin
                start = 1'b0;
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: no done within 40 cycles, expected latency %0d", name, e_lat);
        end else begin
            check({name, "_latency"}, lat, e_lat);
            check({name, "_stall_cycles"}, stall_cnt, e_stall);
            last_hi = e_hi; last_lo = e_lo; last_dbz = e_dbz;
        end
    endtask

    initial begin
        reset = 1'b0; flush = 1'b0; start = 1'b0;
        is_div = 1'b0; is_signed = 1'b0; op1 = 16'h0; op2 = 16'h0;
        #1;
        check("rst_stall", {31'h0, stall}, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_done", {31'h0, done}, 32'h0);
        check("rst_hi", {16'h0, result_hi}, 32'h0);
        check("rst_lo", {16'h0, result_lo}, 32'h0);
        check("rst_dbz", {31'h0, div_by_zero}, 32'h0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;

        //      name         div   sgn   op1       op2       hi        lo        dbz  stall lat poke
        run_op("umul_7x6",   1'b0, 1'b0, 16'h0007, 16'h0006, 16'h0000, 16'h002A, 1'b0, 17, 18, 0);
        run_op("smul_m3x5",  1'b0, 1'b1, 16'hFFFD, 16'h0005, 16'hFFFF, 16'hFFF1, 1'b0, 17, 18, 0);
        run_op("umul_max",   1'b0, 1'b0, 16'hFFFF, 16'hFFFF, 16'hFFFE, 16'h0001, 1'b0, 17, 18, 0);
        run_op("smul_min",   1'b0, 1'b1, 16'h8000, 16'h8000, 16'h4000, 16'h0000, 1'b0, 17, 18, 0);
        run_op("udiv_100_7", 1'b1, 1'b0, 16'h0064, 16'h0007, 16'h0002, 16'h000E, 1'b0, 17, 18, 0);
        run_op("sdiv_m7_2",  1'b1, 1'b1, 16'hFFF9, 16'h0002, 16'hFFFF, 16'hFFFD, 1'b0, 17, 18, 0);
        run_op("sdiv_ovf",   1'b1, 1'b1, 16'h8000, 16'hFFFF, 16'h0000, 16'h8000, 1'b0, 17, 18, 0);
        run_op("div_zero",   1'b1, 1'b0, 16'h04D2, 16'h0000, 16'h04D2, 16'hFFFF, 1'b1,  1,  2, 0);

        // Results and div_by_zero hold after the done pulse.
        repeat (3) @(negedge clk);
        check("hold_hi", {16'h0, result_hi}, {16'h0, last_hi});
        check("hold_lo", {16'h0, result_lo}, {16'h0, last_lo});
        check("hold_dbz", {31'h0, div_by_zero}, {31'h0, last_dbz});

        // A start during BUSY must neither corrupt nor queue a second operation (300*300 = 0x15F90).
        run_op("start_busy", 1'b0, 1'b0, 16'd300, 16'd300, 16'h0001, 16'h5F90, 1'b0, 17, 18, 1);
        repeat (25) @(negedge clk);

        // Flush in the fifth BUSY cycle: back to IDLE, no done, results retained.
        @(posedge clk); #1;
        is_div = 1'b0; is_signed = 1'b0; op1 = 16'h0009; op2 = 16'h0009; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1 flush = 1'b1;
        @(negedge clk);
        check("flush_busy_before", {31'h0, busy}, 32'h1);
        check("flush_done_supp", {31'h0, done}, 32'h0);
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        check("flush_busy_after", {31'h0, busy}, 32'h0);
        check("flush_stall_after", {31'h0, stall}, 32'h0);
        repeat (25) @(negedge clk);
        check("flush_keep_hi", {16'h0, result_hi}, {16'h0, last_hi});
        check("flush_keep_lo", {16'h0, result_lo}, {16'h0, last_lo});

        // Reset mid-BUSY clears everything at once and no done follows.
        @(posedge clk); #1;
        is_div = 1'b0; op1 = 16'h0007; op2 = 16'h0006; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        check("mid_rst_busy", {31'h0, busy}, 32'h0);
        check("mid_rst_stall", {31'h0, stall}, 32'h0);
        check("mid_rst_done", {31'h0, done}, 32'h0);
        check("mid_rst_hi", {16'h0, result_hi}, 32'h0);
        check("mid_rst_lo", {16'h0, result_lo}, 32'h0);
        check("mid_rst_dbz", {31'h0, div_by_zero}, 32'h0);
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (25) @(negedge clk);
        check("post_rst_busy", {31'h0, busy}, 32'h0);

        check("scoreboard_empty", sb_q.size(), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ex_muldiv_unit.md
Name: ex_muldiv_unit

Overview:
- Iterative multiply/divide unit in the EX stage of the 16-bit pipeline.
- Consumes op1/op2 from the ID/EX pipeline register and starts on a start strobe decoded from the EX control field.
- Holds the front of the pipeline through the stall output while it computes.
- Results go to the EX/MEM register when the done strobe is high.

Parameters:
- WIDTH, 16, operand width; results are 2*WIDTH split into hi/lo halves.
- CNT_W, 5, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous active-low reset
- flush  input  1  synchronous abort of the current operation
- start  input  1  request a new operation; sampled only in IDLE
- is_div  input  1  0 = multiply, 1 = divide
- is_signed  input  1  1 = two's-complement operands, 0 = unsigned
- op1  input  WIDTH  multiplicand / dividend
- op2  input  WIDTH  multiplier / divisor
- stall  output  1  hold the IF/ID and ID/EX registers
- busy  output  1  state is not IDLE
- done  output  1  one-cycle pulse; result_hi/result_lo valid
- result_hi  output  WIDTH  product[2W-1:W] / remainder
- result_lo  output  WIDTH  product[W-1:0] / quotient
- div_by_zero  output  1  set with done when a divide had op2 = 0

Behaviour:
- Reset (async, reset = 0):
  - State goes to IDLE.
  - stall, busy, done, div_by_zero, result_hi, result_lo and the counter all go to 0.
- States and transitions:
  - IDLE: start = 1 captures operands, op type and sign info, loads counter = WIDTH, and goes to BUSY.
  - IDLE, divide with op2 = 0: goes straight to DONE instead.
  - BUSY: one shift-add (multiply) or restoring shift-subtract (divide) step per cycle. Counter decrements each cycle. Counter reaching 1 goes to DONE on the next edge.
  - DONE: result registers loaded and done = 1 for exactly this cycle. Always returns to IDLE next edge.
- Latency:
  - Normal operation: start seen at edge 0, done high during the cycle after edge WIDTH+1 (17 cycles for WIDTH = 16).
  - Divide by zero: done high during the cycle after edge 1.
- stall:
  - stall = (IDLE & start) | BUSY. It is combinational, so the ID/EX register holds on the same cycle start appears.
  - stall is low in DONE, so the pipeline advances on the cycle the result is valid.
  - busy = state != IDLE.
- start while busy: ignored, no queueing. The pipeline is stalled, so it cannot occur legally.
- Signed handling:
  - Operands are converted to magnitudes at capture; the algorithm runs unsigned; signs are applied in the DONE load.
  - Product sign = sign(op1) XOR sign(op2).
  - Quotient sign = sign(op1) XOR sign(op2).
  - Remainder sign = sign(op1).
  - Magnitude of -2^(W-1) is 2^(W-1) and needs no extra bit in unsigned form.
- Signed overflow: -32768 / -1 gives quotient 0x8000, remainder 0x0000, div_by_zero = 0.
- Divide by zero: quotient = all ones, remainder = op1 unchanged, div_by_zero = 1. No iteration.
- result_hi, result_lo and div_by_zero hold their values until the next DONE load.
- flush:
  - In BUSY or DONE: goes to IDLE next edge, done suppressed, results unchanged.
  - start in the same cycle as flush in IDLE is ignored.
  - flush has priority over every other event.
- reset mid-operation: immediate IDLE, all outputs 0, no done.

Test Plan:
- Unsigned multiply 7 × 6 (is_div = 0, is_signed = 0) -> stall high 17 cycles, then done with result_hi = 0x0000, result_lo = 0x002A.
- Signed multiply -3 × 5 (op1 = 0xFFFD, op2 = 0x0005) -> result_hi = 0xFFFF, result_lo = 0xFFF1.
- Unsigned divide 100 / 7 -> result_lo = 0x000E, result_hi = 0x0002, div_by_zero = 0.
- Signed divide -7 / 2 -> result_lo = 0xFFFD, result_hi = 0xFFFF.
- Signed divide -32768 / -1 -> result_lo = 0x8000, result_hi = 0x0000.
- Divide 0x04D2 / 0 -> done 2 cycles after start, div_by_zero = 1, result_lo = 0xFFFF, result_hi = 0x04D2.
- Flush in the 5th BUSY cycle -> IDLE next edge, stall low, no done pulse, previous results retained.
- A second start issued during BUSY -> ignored.
- Reset asserted mid-BUSY -> all outputs 0 immediately.
